pkt_ingress_arb: RTL and testbench

PKT_INGRESS_ARB -- requirements
Module: pkt_ingress_arb

---
 rtl/pkt_h.sv | 18 +
 rtl/rr_next_sel.sv | 28 ++
 rtl/pkt_ingress_arb.sv | 141 ++++++++++++++
 tb/tb_pkt_ingress_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_h.sv
// Shared packet header type, statistics width and ingress arbiter state encoding.
package pkt_h;

  localparam int unsigned STAT_W = 32;

  typedef struct packed {
    logic [7:0]  flow_id;
    logic [3:0]  prio;
    logic [3:0]  kind;
    logic [15:0] len;
  } pkHeadInfo;

  typedef enum logic [0:0] {
    StIdle,
    StServe
  } arb_state_e;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: first set request bit at or after start, wrapping around.
module rr_next_sel #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(start) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_ingress_arb.sv
// Weighted round-robin ingress arbiter: grants one requester at a time to the priorer,
// spending per-port credit on each accepted packet.
module pkt_ingress_arb
  import pkt_h::*;
#(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned NPORT    = 4,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_en,
  input  logic [NPORT*WEIGHT_W-1:0] cfg_weight,
  input  logic [NPORT-1:0]          req_valid,
  output logic [NPORT-1:0]          req_ready,
  input  pkHeadInfo [NPORT-1:0]     req_pkt_info,
  input  logic [NPORT*DWIDTH-1:0]   req_data,
  input  logic                      out_ready,
  output logic                      out_en,
  output pkHeadInfo                 out_pkt_info,
  output logic [DWIDTH-1:0]         out_data,
  output logic [$clog2(NPORT)-1:0]  out_port,
  output logic [NPORT*STAT_W-1:0]   stat_cnt
);

  localparam int unsigned PW = $clog2(NPORT);

  arb_state_e                      state_q, state_d;
  logic [PW-1:0]                   ptr_q, ptr_d;
  logic [PW-1:0]                   last_ptr_q, last_ptr_d;
  logic [WEIGHT_W-1:0]             credit_q, credit_d;
  logic [NPORT-1:0][STAT_W-1:0]    stat_q, stat_d;

  logic [NPORT-1:0][WEIGHT_W-1:0]  weight;
  logic [NPORT-1:0][DWIDTH-1:0]    data;
  logic [NPORT-1:0]                eligible;
  logic [PW-1:0]                   search_base;
  logic [PW-1:0]                   search_start;
  logic                            nxt_found;
  logic [PW-1:0]                   nxt_idx;
  logic                            xfer;

  assign weight = cfg_weight;
  assign data   = req_data;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      eligible[i] = cfg_en && req_valid[i] && (weight[i] != '0);
    end
  end

  // IDLE resumes after the last served port; SERVE looks past the current one.
  assign search_base  = (state_q == StIdle) ? last_ptr_q : ptr_q;
  assign search_start = (search_base == PW'(NPORT - 1)) ? '0 : search_base + PW'(1);

  rr_next_sel #(
    .N(NPORT)
  ) u_rr_next_sel (
    .req   (eligible),
    .start (search_start),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  assign xfer = !rst && (state_q == StServe) && eligible[ptr_q] && out_ready;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_ptr_d = last_ptr_q;
    credit_d   = credit_q;
    if (!cfg_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (nxt_found) begin
            state_d  = StServe;
            ptr_d    = nxt_idx;
            credit_d = weight[nxt_idx];
          end
        end
        StServe: begin
          if (xfer && (credit_q > WEIGHT_W'(1))) begin
            credit_d = credit_q - WEIGHT_W'(1);
          end else if (xfer || !eligible[ptr_q]) begin
            if (nxt_found) begin
              ptr_d    = nxt_idx;
              credit_d = weight[nxt_idx];
            end else begin
              state_d    = StIdle;
              last_ptr_d = ptr_q;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready    = '0;
    out_en       = xfer;
    out_port     = '0;
    out_pkt_info = '0;
    out_data     = '0;
    if (xfer) begin
      req_ready[ptr_q] = 1'b1;
      out_port         = ptr_q;
      out_pkt_info     = req_pkt_info[ptr_q];
      out_data         = data[ptr_q];
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (xfer && (stat_q[ptr_q] != '1)) begin
      stat_d[ptr_q] = stat_q[ptr_q] + STAT_W'(1);
    end
  end

  assign stat_cnt = stat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      last_ptr_q <= PW'(NPORT - 1);
      credit_q   <= '0;
      stat_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_ptr_q <= last_ptr_d;
      credit_q   <= credit_d;
      stat_q     <= stat_d;
    end
  end

endmodule

// File: tb/tb_pkt_ingress_arb.sv
// Scoreboard bench for pkt_ingress_arb: directed scenarios push expected grants,
// a forked monitor pops and compares on every out_en.
module tb_pkt_ingress_arb;
  import pkt_h::*;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_en;
  logic [NP*WW-1:0]     cfg_weight;
  logic [NP-1:0]        req_valid;
  logic [NP-1:0]        req_ready;
  pkHeadInfo [NP-1:0]   req_pkt_info;
  logic [NP*DW-1:0]     req_data;
  logic                 out_ready;
  logic                 out_en;
  pkHeadInfo            out_pkt_info;
  logic [DW-1:0]        out_data;
  logic [1:0]           out_port;
  logic [NP*STAT_W-1:0] stat_cnt;

  pkt_ingress_arb #(
    .DWIDTH   (DW),
    .NPORT    (NP),
    .WEIGHT_W (WW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_en       (cfg_en),
    .cfg_weight   (cfg_weight),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_pkt_info (req_pkt_info),
    .req_data     (req_data),
    .out_ready    (out_ready),
    .out_en       (out_en),
    .out_pkt_info (out_pkt_info),
    .out_data     (out_data),
    .out_port     (out_port),
    .stat_cnt     (stat_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          exp_q[$];
  logic [31:0] exp_stat [NP];

  function automatic logic [DW-1:0] data_of(int p);
    return 32'hDA7A_0000 + 32'(p) * 32'h0000_1111;
  endfunction

  function automatic pkHeadInfo info_of(int p);
    pkHeadInfo h;
    h.flow_id = 8'(32'h40 + p);
    h.prio    = 4'(p);
    h.kind    = 4'hA;
    h.len     = 16'(16 * p + 4);
    return h;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(int p);
    exp_q.push_back(p);
    if (exp_stat[p] != 32'hFFFF_FFFF) exp_stat[p] = exp_stat[p] + 32'd1;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_exp_stat();
    for (int i = 0; i < NP; i++) exp_stat[i] = '0;
  endtask

  task automatic check_stats(string name);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("%s_stat%0d", name, i), stat_cnt[i*32 +: 32], exp_stat[i]);
    end
  endtask

  task automatic check_drained(string name);
    check($sformatf("%s_drained", name), exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick(2);
    rst = 1'b0;
    clear_exp_stat();
    check_stats("after_reset");
  endtask

  task automatic monitor_loop();
    int p;
    logic [NP-1:0] oh;
    forever begin
      @(negedge clk);
      if (out_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got port %0d, required no grant", out_port);
        end else begin
          p  = exp_q.pop_front();
          oh = '0;
          oh[p] = 1'b1;
          check("grant_port", out_port, p);
          check("grant_ready", req_ready, oh);
          check("grant_data", out_data, data_of(p));
          check("grant_info", out_pkt_info, info_of(p));
        end
      end else begin
        check("idle_ready", req_ready, 0);
        check("idle_port", out_port, 0);
        check("idle_payload", {out_data, out_pkt_info}, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    cfg_en     = 1'b1;
    cfg_weight = '0;
    req_valid  = '0;
    out_ready  = 1'b1;
    for (int i = 0; i < NP; i++) begin
      req_data[i*DW +: DW] = data_of(i);
      req_pkt_info[i]      = info_of(i);
    end
    clear_exp_stat();
    fork
      monitor_loop();
    join_none

    tick(3);
    rst = 1'b0;
    check_stats("reset");
    check("reset_out_en", out_en, 0);

    // WRR with weights 1..4 on all ports, then arbiter disabled with requests pending.
    cfg_weight = {4'd4, 4'd3, 4'd2, 4'd1};
    req_valid  = 4'hF;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        for (int w = 0; w <= p; w++) push(p);
      end
    end
    tick(21);
    cfg_en = 1'b0;
    tick(3);
    req_valid = '0;
    cfg_en    = 1'b1;
    tick(1);
    check_drained("wrr");
    check_stats("wrr");

    // Lone port 2 is re-granted every cycle.
    do_reset();
    cfg_weight = {4'd1, 4'd2, 4'd1, 4'd1};
    req_valid  = 4'b0100;
    for (int k = 0; k < 7; k++) push(2);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      check("solo_stat2_run", stat_cnt[2*32 +: 32], k - 1);
    end
    req_valid = '0;
    tick(1);
    check_drained("solo");
    check_stats("solo");

    // Back-pressure holds port 1 with its full credit of 3.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd3, 4'd1};
    req_valid  = 4'b0110;
    out_ready  = 1'b0;
    push(1); push(1); push(1); push(2);
    push(1); push(1); push(1); push(2);
    tick(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_ready", req_ready, 0);
      check("stall_out_en", out_en, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    tick(8);
    req_valid = '0;
    tick(1);
    check_drained("stall");
    check_stats("stall");

    // Zero weight disables port 0 even though it requests.
    do_reset();
    cfg_weight = {4'd1, 4'd1, 4'd1, 4'd0};
    req_valid  = 4'hF;
    for (int r = 0; r < 3; r++) begin
      push(1); push(2); push(3);
    end
    tick(10);
    req_valid = '0;
    tick(1);
    check_drained("zero_weight");
    check_stats("zero_weight");

    // Reset while serving port 3; search restarts at port 0.
    do_reset();
    cfg_weight = {4'd4, 4'd1, 4'd1, 4'd1};
    req_valid  = 4'hF;
    push(0); push(1); push(2); push(3); push(3);
    tick(6);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_en", out_en, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_port", out_port, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_exp_stat();
    check_stats("midrst_cleared");
    push(0); push(1); push(2); push(3);
    tick(5);
    req_valid = '0;
    tick(1);
    check_drained("midrst");
    check_stats("midrst");

    // Counter preset just below the ceiling must saturate.
    do_reset();
    force dut.stat_q = {32'h0, 32'hFFFF_FFFD, 32'h0, 32'h0};
    #2;
    release dut.stat_q;
    exp_stat[2] = 32'hFFFF_FFFD;
    cfg_weight  = {4'd1, 4'd1, 4'd1, 4'd1};
    req_valid   = 4'b0100;
    for (int k = 0; k < 5; k++) push(2);
    tick(6);
    req_valid = '0;
    tick(1);
    check_drained("sat");
    check_stats("sat");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
